// File: rtl/window3x3_linebuf_stream.sv
// rtl/window3x3_linebuf_stream.sv - streaming bordered 3x3 window generator over two line buffers
// Define WIN_REPLICATE_PAD_EN for edge-replicated borders; otherwise borders are zero padded.

module window3x3_linebuf_stream #(
    parameter int DATA_W = 24,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iPixel,
    output logic              oReady,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oOut0,
    output logic [DATA_W-1:0] oOut1,
    output logic [DATA_W-1:0] oOut2,
    output logic [DATA_W-1:0] oOut3,
    output logic [DATA_W-1:0] oOut4,
    output logic [DATA_W-1:0] oOut5,
    output logic [DATA_W-1:0] oOut6,
    output logic [DATA_W-1:0] oOut7,
    output logic [DATA_W-1:0] oOut8,
    output logic              oLast,
    output logic              oFrameDone
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(HEIGHT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     colCnt;
    logic [CW-1:0]     qCol;
    logic [RW-1:0]     rowCnt;
    logic [RW-1:0]     qRow;
    logic [DATA_W-1:0] lineBuf0 [WIDTH];
    logic [DATA_W-1:0] lineBuf1 [WIDTH];
    logic [DATA_W-1:0] tapA [3];
    logic [DATA_W-1:0] tapB [3];
    logic [DATA_W-1:0] rawWin [9];
    logic [DATA_W-1:0] win [9];
    logic [DATA_W-1:0] outWin [9];
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] lb0Rd;
    logic [DATA_W-1:0] lb1Rd;
    logic              slotFree;
    logic              step;
    logic              handshake;
    logic              emit;
    logic              lastPixel;

    // Once the last window is held, flushing stops until it is taken.
    assign slotFree   = !oValid || iReady;
    assign oReady     = iEn && (state == RUN) && slotFree;
    assign step       = iEn && slotFree &&
                        (((state == RUN) && iValid) || ((state == FLUSH) && !(oValid && oLast)));
    assign handshake  = iEn && oValid && iReady;
    assign din        = (state == RUN) ? iPixel : '0;
    assign lb0Rd      = lineBuf0[colCnt];
    assign lb1Rd      = lineBuf1[colCnt];
    assign emit       = (rowCnt >= RW'(2)) || ((rowCnt != '0) && (colCnt != '0));
    assign lastPixel  = (colCnt == COL_LAST) && (rowCnt == ROW_LAST);
    assign oFrameDone = (state == DONE);

    always_comb begin
        rawWin[0] = tapA[0];
        rawWin[1] = tapB[0];
        rawWin[2] = lb1Rd;
        rawWin[3] = tapA[1];
        rawWin[4] = tapB[1];
        rawWin[5] = lb0Rd;
        rawWin[6] = tapA[2];
        rawWin[7] = tapB[2];
        rawWin[8] = din;
    end

    // Rows are resolved before columns so replicated corners become the centre pixel.
    always_comb begin
        win = rawWin;
        for (int j = 0; j < 3; j++) begin
`ifdef WIN_REPLICATE_PAD_EN
            if (qRow == '0)      win[j]     = win[3 + j];
            if (qRow == ROW_LAST) win[6 + j] = win[3 + j];
`else
            if (qRow == '0)      win[j]     = '0;
            if (qRow == ROW_LAST) win[6 + j] = '0;
`endif
        end
        for (int i = 0; i < 3; i++) begin
`ifdef WIN_REPLICATE_PAD_EN
            if (qCol == '0)      win[3 * i]     = win[3 * i + 1];
            if (qCol == COL_LAST) win[3 * i + 2] = win[3 * i + 1];
`else
            if (qCol == '0)      win[3 * i]     = '0;
            if (qCol == COL_LAST) win[3 * i + 2] = '0;
`endif
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state  <= IDLE;
            colCnt <= '0;
            rowCnt <= '0;
            qCol   <= '0;
            qRow   <= '0;
            oValid <= 1'b0;
            oLast  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                tapA[k] <= '0;
                tapB[k] <= '0;
            end
            for (int k = 0; k < 9; k++) outWin[k] <= '0;
        end else if (iEn) begin
            case (state)
                IDLE:    state <= RUN;
                RUN:     if (step && lastPixel) state <= FLUSH;
                FLUSH:   if (handshake && oLast) state <= DONE;
                default: begin
                    state  <= IDLE;
                    colCnt <= '0;
                    rowCnt <= '0;
                    qCol   <= '0;
                    qRow   <= '0;
                    for (int k = 0; k < 3; k++) begin
                        tapA[k] <= '0;
                        tapB[k] <= '0;
                    end
                end
            endcase
            if (step) begin
                colCnt <= (colCnt == COL_LAST) ? '0 : colCnt + 1'b1;
                if ((colCnt == COL_LAST) && (rowCnt != ROW_END)) rowCnt <= rowCnt + 1'b1;
                for (int k = 0; k < 3; k++) tapA[k] <= tapB[k];
                tapB[0] <= lb1Rd;
                tapB[1] <= lb0Rd;
                tapB[2] <= din;
                if (emit) begin
                    qCol <= (qCol == COL_LAST) ? '0 : qCol + 1'b1;
                    if (qCol == COL_LAST) qRow <= qRow + 1'b1;
                end
            end
            if (step && emit) begin
                oValid <= 1'b1;
                oLast  <= (qCol == COL_LAST) && (qRow == ROW_LAST);
                outWin <= win;
            end else if (handshake) begin
                oValid <= 1'b0;
                oLast  <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst && step) begin
            lineBuf0[colCnt] <= din;
            lineBuf1[colCnt] <= lb0Rd;
        end
    end

    assign oOut0 = outWin[0];
    assign oOut1 = outWin[1];
    assign oOut2 = outWin[2];
    assign oOut3 = outWin[3];
    assign oOut4 = outWin[4];
    assign oOut5 = outWin[5];
    assign oOut6 = outWin[6];
    assign oOut7 = outWin[7];
    assign oOut8 = outWin[8];

endmodule

// File: tb/tb_window3x3_linebuf_stream.sv
// tb/tb_window3x3_linebuf_stream.sv - scoreboard bench for window3x3_linebuf_stream
// Honours WIN_REPLICATE_PAD_EN in its reference model and directed constants.

module tb_window3x3_linebuf_stream;
    localparam int DW = 24;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NP = W * H;

    typedef logic [9*DW-1:0] win_t;
    typedef struct packed {
        logic last;
        win_t w;
    } exp_t;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iEn = 1'b0;
    logic          iValid = 1'b0;
    logic          iReady = 1'b1;
    logic [DW-1:0] iPixel = '0;
    logic          oReady, oValid, oLast, oFrameDone;
    logic [DW-1:0] oOut0, oOut1, oOut2, oOut3, oOut4, oOut5, oOut6, oOut7, oOut8;
    win_t          dutWin;

    window3x3_linebuf_stream #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iValid(iValid), .iPixel(iPixel),
        .oReady(oReady), .oValid(oValid), .iReady(iReady),
        .oOut0(oOut0), .oOut1(oOut1), .oOut2(oOut2), .oOut3(oOut3), .oOut4(oOut4),
        .oOut5(oOut5), .oOut6(oOut6), .oOut7(oOut7), .oOut8(oOut8),
        .oLast(oLast), .oFrameDone(oFrameDone)
    );

    assign dutWin = {oOut8, oOut7, oOut6, oOut5, oOut4, oOut3, oOut2, oOut1, oOut0};

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int            total = 0;
    int            bad = 0;
    exp_t          sbQ[$];
    win_t          obs[$];
    logic [DW-1:0] img[NP];
    int            frameId = 0;
    int            rdyMode = 0;
    int            rdyPh = 0;
    int            lastAcceptCyc = 0;
    int            frameDoneCnt = 0;
    int            lastHsCyc = -10;
    int            firstValidCyc = -1;

    task automatic chkW(input string name, input win_t got, input win_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chkI(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic win_t pack9(input int t0, input int t1, input int t2, input int t3,
                                   input int t4, input int t5, input int t6, input int t7,
                                   input int t8);
        return {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
    endfunction

    // Neighbourhood of (r,c) straight from the image: out-of-frame taps are zero or clamped.
    function automatic win_t modelWin(input int r, input int c);
        win_t          res;
        int            rr;
        int            cc;
        logic [DW-1:0] v;
        res = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
`ifdef WIN_REPLICATE_PAD_EN
                rr = (rr < 0) ? 0 : ((rr > H - 1) ? H - 1 : rr);
                cc = (cc < 0) ? 0 : ((cc > W - 1) ? W - 1 : cc);
                v = img[rr * W + cc];
`else
                if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = '0;
                else v = img[rr * W + cc];
`endif
                res[((dr + 1) * 3 + (dc + 1)) * DW +: DW] = v;
            end
        end
        return res;
    endfunction

    initial begin
        forever begin
            @(posedge iClk);
            #1;
            case (rdyMode)
                0:       iReady = 1'b1;
                1:       iReady = (rdyPh == 0);
                default: iReady = 1'($urandom_range(0, 1));
            endcase
            rdyPh = (rdyPh == 2) ? 0 : rdyPh + 1;
        end
    end

    // Monitor: pops the scoreboard on each handshake and watches hold/ready/done rules.
    initial begin
        win_t prevW;
        logic prevV;
        logic prevL;
        bit   prevPend;
        int   seenFrame;
        exp_t e;
        prevPend  = 0;
        seenFrame = 0;
        forever begin
            @(negedge iClk);
            if (frameId != seenFrame) begin
                seenFrame = frameId;
                obs.delete();
                firstValidCyc = -1;
            end
            if (!iRst) begin
                prevPend = 0;
            end else begin
                if (prevPend) begin
                    chkW("hold_taps", dutWin, prevW);
                    chkI("hold_valid", int'(oValid), int'(prevV));
                    chkI("hold_last", int'(oLast), int'(prevL));
                end
                if (oValid && !iReady) chkI("ready_blocked", int'(oReady), 0);
                if (oFrameDone) begin
                    frameDoneCnt++;
                    chkI("done_timing", cyc, lastHsCyc + 1);
                end
                if (oValid && firstValidCyc < 0) firstValidCyc = cyc;
                if (oValid && iReady && iEn) begin
                    if (sbQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_window: got %0h expected none", dutWin);
                    end else begin
                        e = sbQ.pop_front();
                        chkW("window", dutWin, e.w);
                        chkI("last", int'(oLast), int'(e.last));
                    end
                    obs.push_back(dutWin);
                    lastHsCyc = cyc;
                end
                prevPend = oValid && !(iReady && iEn);
                prevW    = dutWin;
                prevV    = oValid;
                prevL    = oLast;
            end
        end
    end

    task automatic sendPix(input logic [DW-1:0] v);
        bit ok;
        ok     = 0;
        iValid = 1'b1;
        iPixel = v;
        for (int t = 0; t < 300; t++) begin
            @(negedge iClk);
            if (oReady) begin
                ok = 1;
                lastAcceptCyc = cyc;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no oReady expected acceptance of %0h", v);
        end
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic runFrame(input int nPix, input int base, input bit rnd, input int gapMax,
                            input int stallAt, output int hs5);
        exp_t e;
        win_t snap;
        logic sv;
        int   g;
        frameId++;
        for (int i = 0; i < NP; i++) img[i] = rnd ? DW'($urandom) : DW'(base + i);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                e.last = (r == H - 1) && (c == W - 1);
                e.w    = modelWin(r, c);
                sbQ.push_back(e);
            end
        end
        hs5 = -1;
        for (int i = 0; i < nPix; i++) begin
            if (gapMax > 0) begin
                g = $urandom_range(0, gapMax);
                for (int k = 0; k < g; k++) begin
                    @(posedge iClk);
                    #1;
                end
            end
            if (i == stallAt) begin
                iEn    = 1'b0;
                iValid = 1'b1;
                iPixel = img[i];
                snap   = dutWin;
                sv     = oValid;
                for (int k = 0; k < 5; k++) begin
                    @(negedge iClk);
                    chkI("stall_ready", int'(oReady), 0);
                    chkW("stall_taps", dutWin, snap);
                    chkI("stall_valid", int'(oValid), int'(sv));
                    @(posedge iClk);
                    #1;
                end
                iEn = 1'b1;
            end
            sendPix(img[i]);
            if (i == W + 1) hs5 = lastAcceptCyc;
        end
        iValid = 1'b0;
    endtask

    task automatic waitDone();
        int  start;
        bit  seen;
        start = frameDoneCnt;
        seen  = 0;
        for (int t = 0; t < 500; t++) begin
            @(posedge iClk);
            #1;
            if (frameDoneCnt > start) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no oFrameDone expected one pulse");
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge iClk);
            #1;
        end
        chkI("done_count", frameDoneCnt, start + 1);
        chkI("queue_empty", sbQ.size(), 0);
    endtask

    initial begin
        int hs;
        iRst = 1'b0;
        iEn  = 1'b0;
        for (int k = 0; k < 3; k++) @(posedge iClk);
        @(negedge iClk);
        chkI("rst_valid", int'(oValid), 0);
        chkI("rst_ready", int'(oReady), 0);
        chkI("rst_last", int'(oLast), 0);
        chkI("rst_done", int'(oFrameDone), 0);
        chkW("rst_taps", dutWin, '0);
        @(posedge iClk);
        #1;
        iRst = 1'b1;
        iEn  = 1'b1;

        rdyMode = 0;
        runFrame(NP, 1, 0, 0, -1, hs);
        waitDone();
        chkI("latency", firstValidCyc, hs + 1);
        chkI("obs_count", obs.size(), NP);
`ifdef WIN_REPLICATE_PAD_EN
        chkW("win_c00", obs[0], pack9(1, 1, 2, 1, 1, 2, 5, 5, 6));
        chkW("win_c11", obs[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        chkW("win_c23", obs[11], pack9(7, 8, 8, 11, 12, 12, 11, 12, 12));
`else
        chkW("win_c00", obs[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chkW("win_c11", obs[5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        chkW("win_c23", obs[11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));
`endif

        rdyMode = 1;
        runFrame(NP, 1, 0, 2, 6, hs);
        waitDone();
        chkI("obs_count_bp", obs.size(), NP);

        rdyMode = 2;
        runFrame(NP, 0, 1, 1, -1, hs);
        waitDone();

        rdyMode = 0;
        runFrame(7, 1, 0, 0, -1, hs);
        for (int k = 0; k < 3; k++) begin
            @(posedge iClk);
            #1;
        end
        iRst = 1'b0;
        for (int k = 0; k < 2; k++) @(posedge iClk);
        @(negedge iClk);
        chkI("midrst_valid", int'(oValid), 0);
        chkI("midrst_ready", int'(oReady), 0);
        chkW("midrst_taps", dutWin, '0);
        @(posedge iClk);
        #1;
        sbQ.delete();
        iRst = 1'b1;

        runFrame(NP, 101, 0, 0, -1, hs);
        waitDone();
`ifdef WIN_REPLICATE_PAD_EN
        chkW("win_after_rst", obs[0], pack9(101, 101, 102, 101, 101, 102, 105, 105, 106));
`else
        chkW("win_after_rst", obs[0], pack9(0, 0, 0, 0, 101, 102, 0, 105, 106));
`endif
        chkI("frames_done", frameDoneCnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
